// File: rtl/spi_cmem_bridge.sv
// rtl/spi_cmem_bridge.sv - SPI mode-0 slave that turns host frames into single cmem nibble accesses
module spi_cmem_bridge #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] ID_BYTE     = 8'hA3
) (
  input  logic       clk200,
  input  logic       rst,
  input  logic       spi_sck,
  input  logic       spi_ss_n,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       spi_read,
  output logic       spi_write,
  output logic [3:0] spi_address,
  output logic [3:0] spi_out_cmem_in,
  input  logic [3:0] spi_in_cmem_out
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_READ,
    ST_WRITE,
    ST_DISCARD
  } state_t;

  logic [SYNC_STAGES-1:0] r_sck_sync;
  logic [SYNC_STAGES-1:0] r_ss_n_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   r_sck_prev;

  logic                   w_sck;
  logic                   w_ss_n;
  logic                   w_mosi;
  logic                   w_rise;
  logic                   w_fall;

  state_t                 r_state;
  state_t                 w_next_state;
  logic                   r_armed;

  logic [2:0]             r_bit_cnt;
  logic [6:0]             r_shift_in;
  logic [7:0]             r_shift_out;

  logic [3:0]             r_addr;
  logic [3:0]             r_addr_out;
  logic [3:0]             r_wdata;
  logic                   r_read;
  logic                   r_write;
  logic                   r_capture;

  logic                   w_do_read;
  logic                   w_do_write;
  logic                   w_latch_cmd;
  logic                   w_load_id;
  logic [1:0]             w_cmd_op;
  logic [3:0]             w_low_nibble;

  assign w_sck  = r_sck_sync[SYNC_STAGES-1];
  assign w_ss_n = r_ss_n_sync[SYNC_STAGES-1];
  assign w_mosi = r_mosi_sync[SYNC_STAGES-1];
  assign w_rise = w_sck & ~r_sck_prev;
  assign w_fall = ~w_sck & r_sck_prev;

  // The 7 bits already shifted plus the live MOSI bit form the complete byte on the 8th rise.
  assign w_cmd_op     = r_shift_in[6:5];
  assign w_low_nibble = {r_shift_in[2:0], w_mosi};

  assign spi_miso        = r_shift_out[7];
  assign spi_read        = r_read;
  assign spi_write       = r_write;
  assign spi_address     = r_addr_out;
  assign spi_out_cmem_in = r_wdata;

  // Bring the asynchronous SPI pins into clk200 and keep the previous SCK for edge detection.
  always_ff @(posedge clk200 or posedge rst) begin
    if (rst) begin
      r_sck_sync  <= '0;
      r_ss_n_sync <= '0;
      r_mosi_sync <= '0;
      r_sck_prev  <= 1'b0;
    end else begin
      r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], spi_sck};
      r_ss_n_sync <= {r_ss_n_sync[SYNC_STAGES-2:0], spi_ss_n};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      r_sck_prev  <= w_sck;
    end
  end

  // A frame may only start once SS_n has been seen high, so a reset mid-frame waits for a fresh select.
  always_ff @(posedge clk200 or posedge rst) begin
    if (rst) begin
      r_armed <= 1'b0;
    end else if (w_ss_n) begin
      r_armed <= 1'b1;
    end
  end

  // Frame state register.
  always_ff @(posedge clk200 or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode and the per-byte access decisions; deselect wins over everything.
  always_comb begin
    w_next_state = r_state;
    w_do_read    = 1'b0;
    w_do_write   = 1'b0;
    w_latch_cmd  = 1'b0;
    w_load_id    = 1'b0;
    if (w_ss_n) begin
      w_next_state = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (r_armed) begin
            w_next_state = ST_CMD;
            w_load_id    = 1'b1;
          end
        end
        ST_CMD: begin
          if (w_rise && (r_bit_cnt == 3'd7)) begin
            w_latch_cmd = 1'b1;
            case (w_cmd_op)
              2'b01:   w_next_state = ST_READ;
              2'b10:   w_next_state = ST_WRITE;
              default: w_next_state = ST_DISCARD;
            endcase
          end
        end
        ST_READ: begin
          // Reading on the first bit leaves the rest of the byte to fetch and present the nibble.
          if (w_rise && (r_bit_cnt == 3'd0)) begin
            w_do_read = 1'b1;
          end
        end
        ST_WRITE: begin
          // Writing only on the last bit means a truncated byte never reaches cmem.
          if (w_rise && (r_bit_cnt == 3'd7)) begin
            w_do_write = 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Count bits and shift MOSI in on each synced SCK rise; cleared whenever the frame is not active.
  always_ff @(posedge clk200 or posedge rst) begin
    if (rst) begin
      r_bit_cnt  <= 3'd0;
      r_shift_in <= 7'd0;
    end else if (w_next_state == ST_IDLE) begin
      r_bit_cnt  <= 3'd0;
      r_shift_in <= 7'd0;
    end else if (w_rise) begin
      r_bit_cnt  <= r_bit_cnt + 3'd1;
      r_shift_in <= {r_shift_in[5:0], w_mosi};
    end
  end

  // MISO shifter: ID byte during the command, read nibble in READ, zero otherwise; moves on SCK falls.
  always_ff @(posedge clk200 or posedge rst) begin
    if (rst) begin
      r_shift_out <= 8'h00;
    end else if (w_next_state == ST_IDLE) begin
      r_shift_out <= 8'h00;
    end else if (w_load_id) begin
      r_shift_out <= ID_BYTE;
    end else if ((r_state == ST_READ) && r_capture) begin
      r_shift_out <= {4'b0000, spi_in_cmem_out};
    end else if (w_fall) begin
      // A fall with the counter wrapped closes a byte; every byte after the command starts at zero.
      r_shift_out <= (r_bit_cnt == 3'd0) ? 8'h00 : {r_shift_out[6:0], 1'b0};
    end
  end

  // Issue one-cycle strobes, hold address/data between them, and step the address after each access.
  always_ff @(posedge clk200 or posedge rst) begin
    if (rst) begin
      r_read     <= 1'b0;
      r_write    <= 1'b0;
      r_capture  <= 1'b0;
      r_addr     <= 4'd0;
      r_addr_out <= 4'd0;
      r_wdata    <= 4'd0;
    end else begin
      r_read    <= w_do_read;
      r_write   <= w_do_write;
      r_capture <= r_read;
      if (w_latch_cmd) begin
        r_addr <= w_low_nibble;
      end else if (w_do_read || w_do_write) begin
        r_addr_out <= r_addr;
        r_addr     <= r_addr + 4'd1;
      end
      if (w_do_write) begin
        r_wdata <= w_low_nibble;
      end
    end
  end

endmodule

// File: tb/tb_spi_cmem_bridge.sv
// tb/tb_spi_cmem_bridge.sv - self-checking bench for spi_cmem_bridge against a frame-level model
`timescale 1ns/1ps
module tb_spi_cmem_bridge;

  localparam logic [7:0] ID = 8'hA3;

  typedef struct packed {
    logic [1:0] kind;
    logic [3:0] addr;
    logic [3:0] data;
  } strobe_t;

  logic       clk200   = 1'b0;
  logic       rst      = 1'b1;
  logic       spi_sck  = 1'b0;
  logic       spi_ss_n = 1'b1;
  logic       spi_mosi = 1'b0;
  logic       spi_miso;
  logic       spi_read;
  logic       spi_write;
  logic [3:0] spi_address;
  logic [3:0] spi_out_cmem_in;
  logic [3:0] spi_in_cmem_out = 4'd0;

  logic [3:0] mem      [16];
  logic [3:0] init_mem [16];
  logic [3:0] ref_mem  [16];
  logic       mem_load = 1'b1;

  strobe_t    obs_q[$];
  strobe_t    exp_q[$];
  int         both_cnt = 0;
  logic [7:0] tx_data [8];

  int n_checks = 0;
  int n_pass   = 0;

  always #2.5 clk200 = ~clk200;

  spi_cmem_bridge #(.SYNC_STAGES(2), .ID_BYTE(ID)) dut (
    .clk200          (clk200),
    .rst             (rst),
    .spi_sck         (spi_sck),
    .spi_ss_n        (spi_ss_n),
    .spi_mosi        (spi_mosi),
    .spi_miso        (spi_miso),
    .spi_read        (spi_read),
    .spi_write       (spi_write),
    .spi_address     (spi_address),
    .spi_out_cmem_in (spi_out_cmem_in),
    .spi_in_cmem_out (spi_in_cmem_out)
  );

  // cmem model: registered read data, one cycle after the read strobe
  always @(posedge clk200) begin
    if (mem_load) begin
      for (int i = 0; i < 16; i++) mem[i] <= init_mem[i];
    end else begin
      if (spi_write) mem[spi_address] <= spi_out_cmem_in;
      if (spi_read) spi_in_cmem_out <= mem[spi_address];
    end
  end

  // strobe monitor, sampled mid-cycle
  always @(negedge clk200) begin
    strobe_t s;
    if (spi_read && spi_write) both_cnt++;
    if (spi_read) begin
      s.kind = 2'd1; s.addr = spi_address; s.data = 4'd0;
      obs_q.push_back(s);
    end
    if (spi_write) begin
      s.kind = 2'd2; s.addr = spi_address; s.data = spi_out_cmem_in;
      obs_q.push_back(s);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic spi_xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = tx[7-i];
      repeat (5) @(negedge clk200);
      rx[7-i] = spi_miso;
      spi_sck = 1'b1;
      repeat (5) @(negedge clk200);
      spi_sck = 1'b0;
    end
  endtask

  // One frame: command, nbytes full data bytes from tx_data, then `partial` bits of tx_data[nbytes].
  task automatic run_frame(input string name, input logic [7:0] cmd, input int nbytes, input int partial);
    logic [7:0] rx;
    logic [7:0] exp_rx;
    int         a;
    int         base;
    int         nobs;
    strobe_t    s;
    base = obs_q.size();
    exp_q.delete();
    a = int'(cmd[3:0]);
    spi_ss_n = 1'b0;
    repeat (6) @(negedge clk200);
    spi_xfer(cmd, 8, rx);
    check($sformatf("%s id", name), 32'(rx), 32'(ID));
    for (int k = 0; k < nbytes; k++) begin
      exp_rx = 8'h00;
      if (cmd[7:6] == 2'b01) begin
        exp_rx = {4'h0, ref_mem[a]};
        s.kind = 2'd1; s.addr = 4'(a); s.data = 4'd0;
        exp_q.push_back(s);
        a = (a + 1) % 16;
      end else if (cmd[7:6] == 2'b10) begin
        s.kind = 2'd2; s.addr = 4'(a); s.data = tx_data[k][3:0];
        exp_q.push_back(s);
        ref_mem[a] = tx_data[k][3:0];
        a = (a + 1) % 16;
      end
      spi_xfer(tx_data[k], 8, rx);
      check($sformatf("%s miso b%0d", name, k), 32'(rx), 32'(exp_rx));
    end
    if (partial > 0) begin
      if (cmd[7:6] == 2'b01) begin
        s.kind = 2'd1; s.addr = 4'(a); s.data = 4'd0;
        exp_q.push_back(s);
      end
      spi_xfer(tx_data[nbytes], partial, rx);
    end
    repeat (3) @(negedge clk200);
    spi_ss_n = 1'b1;
    repeat (8) @(negedge clk200);
    nobs = obs_q.size() - base;
    check($sformatf("%s strobe count", name), 32'(nobs), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < nobs; i++) begin
      check($sformatf("%s strobe %0d", name, i), 32'(obs_q[base+i]), 32'(exp_q[i]));
    end
  endtask

  initial begin
    logic [7:0] rx;
    int         base;
    for (int i = 0; i < 16; i++) begin
      init_mem[i] = 4'($urandom);
    end
    init_mem[5] = 4'h9;
    for (int i = 0; i < 16; i++) ref_mem[i] = init_mem[i];

    // reset state
    repeat (3) @(negedge clk200);
    check("reset outputs", 32'({spi_read, spi_write, spi_address, spi_out_cmem_in, spi_miso}), 32'd0);
    rst      = 1'b0;
    repeat (2) @(negedge clk200);
    mem_load = 1'b0;
    repeat (4) @(negedge clk200);

    // single read
    run_frame("single_read", 8'h45, 1, 0);

    // burst write across the address wrap
    tx_data[0] = 8'h01; tx_data[1] = 8'h02; tx_data[2] = 8'h03;
    run_frame("burst_write", 8'h8E, 3, 0);

    // read aborted after 3 bits of the first data byte
    tx_data[0] = 8'h00;
    run_frame("read_abort", 8'h4C, 0, 3);

    // no-op command
    tx_data[0] = 8'h5A; tx_data[1] = 8'hFF;
    run_frame("noop", 8'hC3, 2, 0);

    // burst read, includes the address written by the wrap
    run_frame("burst_read", 8'h4A, 3, 0);
    run_frame("wrap_read", 8'h4F, 2, 0);

    // write with a partial trailing byte: the partial byte must not be written
    tx_data[0] = 8'h3C; tx_data[1] = 8'hA7;
    run_frame("write_partial", 8'h82, 1, 6);

    // reset in the middle of a write data byte
    base     = obs_q.size();
    spi_ss_n = 1'b0;
    repeat (6) @(negedge clk200);
    spi_xfer(8'h81, 8, rx);
    spi_xfer(8'h05, 4, rx);
    rst = 1'b1;
    @(negedge clk200);
    check("midreset outputs", 32'({spi_read, spi_write, spi_address, spi_out_cmem_in, spi_miso}), 32'd0);
    rst = 1'b0;
    spi_xfer(8'h05, 4, rx);
    spi_xfer(8'h47, 8, rx);
    check("midreset miso", 32'(rx), 32'd0);
    repeat (3) @(negedge clk200);
    spi_ss_n = 1'b1;
    repeat (8) @(negedge clk200);
    check("midreset strobes", 32'(obs_q.size() - base), 32'd0);
    run_frame("after_reset", 8'h41, 2, 0);

    // randomized frames
    for (int f = 0; f < 20; f++) begin
      logic [7:0] cmd;
      int         nb;
      int         pb;
      cmd = 8'($urandom);
      nb  = int'($urandom_range(0, 4));
      pb  = int'($urandom_range(0, 7));
      for (int k = 0; k < 8; k++) tx_data[k] = 8'($urandom);
      run_frame($sformatf("rand%0d", f), cmd, nb, pb);
    end

    check("never both strobes", 32'(both_cnt), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
